// File: rtl/data_sram_responder_if.sv
// ---------------------------------------------------------------------------
// data_sram_responder_if
//
// Bundles the CPU's SRAM-like data-memory bus.
//
// Handshake:
//   - A request is taken on a rising clock edge when data_sram_req and
//     data_sram_addr_ok are both high in the cycle before that edge. The
//     request fields (wr, size, addr, wstrb, wdata) only matter in that
//     cycle. The requester may keep req high while addr_ok is low. The
//     request is then taken in the first cycle in which addr_ok rises.
//   - data_sram_data_ok is a one-cycle pulse, one per accepted request, in
//     acceptance order. data_sram_rdata is meaningful only while data_ok is
//     high. There is no ready signal on the response side: the requester
//     must always take it.
//
// Modports:
//   master : pipeline side (drives the request, receives addr_ok/data_ok/rdata)
//   slave  : memory side   (receives the request, drives addr_ok/data_ok/rdata)
// ---------------------------------------------------------------------------
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_addr,
        output data_sram_wstrb,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_addr,
        input  data_sram_wstrb,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Memory end of the CPU data-SRAM bus. It holds a word-organised RAM with
// byte-strobe writes. Every request is answered after a fixed latency, and
// responses come back in order. A small circular queue holds the requests
// that have been accepted but not yet answered.
//
// Ports:
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   addr_stall : backpressure from the bench; forces addr_ok low
//   bus        : data_sram_responder_if.slave (req/wr/size/addr/wstrb/wdata
//                in; addr_ok/data_ok/rdata out)
//
// Parameters:
//   ADDR_WIDTH  : log2 of the memory depth in 32-bit words
//   LATENCY     : cycles from acceptance to data_ok (1..8)
//   OUTSTANDING : maximum number of accepted-but-unanswered requests (1..8)
// ---------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        addr_stall,
    data_sram_responder_if.slave        bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
    localparam logic [2:0]       LAT_INIT = 3'(LATENCY - 1);

    // Storage
    logic [31:0] mem_q [DEPTH];

    // Queue state
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ent_wr_q   [OUTSTANDING];
    logic             ent_wr_d   [OUTSTANDING];
    logic [31:0]      ent_data_q [OUTSTANDING];
    logic [31:0]      ent_data_d [OUTSTANDING];
    logic [2:0]       ent_cnt_q  [OUTSTANDING];
    logic [2:0]       ent_cnt_d  [OUTSTANDING];

    // Datapath
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic                  addr_ok;
    logic                  data_ok;
    logic                  accept;

    // The size field is informational (wstrb decides what is written).
    // The byte offset and the address bits above the RAM are ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign word_idx = bus.data_sram_addr[ADDR_WIDTH+1:2];
    assign cur_word = mem_q[word_idx];

    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_wstrb[i]) begin
                merged_word[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    // The head answers once its countdown has reached zero.
    assign data_ok = (count_q != '0) && (ent_cnt_q[rd_ptr_q] == 3'd0);

    // A full queue can still accept in the cycle where its head leaves.
    // This lets LATENCY=1 sustain one request per cycle, even with a
    // single-entry queue.
    assign addr_ok = resetn & ~addr_stall & ((count_q < MAX_CNT) | data_ok);
    assign accept  = bus.data_sram_req & addr_ok;

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = data_ok;
    assign bus.data_sram_rdata   = (data_ok && !ent_wr_q[rd_ptr_q]) ?
                                   ent_data_q[rd_ptr_q] : 32'd0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < OUTSTANDING; i++) begin
            ent_wr_d[i]   = ent_wr_q[i];
            ent_data_d[i] = ent_data_q[i];
            // Stale slots also count down. This is harmless because a push
            // always reloads the countdown.
            ent_cnt_d[i]  = (ent_cnt_q[i] != 3'd0) ? ent_cnt_q[i] - 3'd1 : 3'd0;
        end
        if (accept) begin
            // The memory word seen before this edge's write is captured,
            // so a load sees all earlier stores and no later one.
            ent_wr_d[wr_ptr_q]   = bus.data_sram_wr;
            ent_data_d[wr_ptr_q] = cur_word;
            ent_cnt_d[wr_ptr_q]  = LAT_INIT;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (data_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(data_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent_wr_q[i]   <= 1'b0;
                ent_data_q[i] <= 32'd0;
                ent_cnt_q[i]  <= 3'd0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent_wr_q[i]   <= ent_wr_d[i];
                ent_data_q[i] <= ent_data_d[i];
                ent_cnt_q[i]  <= ent_cnt_d[i];
            end
        end
    end

    // Memory contents survive reset. addr_ok is low during reset, so no
    // write can happen then.
    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            mem_q[word_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//
// Three responders with different latency and queue depth share one
// stimulus driver, and each has its own request line:
//   u_l1 : LATENCY=1, OUTSTANDING=1
//   u_l3 : LATENCY=3, OUTSTANDING=2
//   u_l4 : LATENCY=4, OUTSTANDING=2
// Every expected response holds {due_cycle, rdata}. It is pushed when the
// bench drives a request it expects to be accepted. A negedge monitor pops
// the entry on data_ok and checks both the data and the cycle.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

    logic clk;
    logic resetn;
    logic addr_stall;

    logic        req_l1, req_l3, req_l4;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic [15:0] cyc;
    int          checks = 0;
    int          errors = 0;

    logic [47:0] exp_q_l1[$];
    logic [47:0] exp_q_l3[$];
    logic [47:0] exp_q_l4[$];
    logic [47:0] e1, e3, e4;

    data_sram_responder_if if_l1 ();
    data_sram_responder_if if_l3 ();
    data_sram_responder_if if_l4 ();

    assign if_l1.data_sram_req   = req_l1;
    assign if_l1.data_sram_wr    = wr;
    assign if_l1.data_sram_size  = size;
    assign if_l1.data_sram_addr  = addr;
    assign if_l1.data_sram_wstrb = wstrb;
    assign if_l1.data_sram_wdata = wdata;

    assign if_l3.data_sram_req   = req_l3;
    assign if_l3.data_sram_wr    = wr;
    assign if_l3.data_sram_size  = size;
    assign if_l3.data_sram_addr  = addr;
    assign if_l3.data_sram_wstrb = wstrb;
    assign if_l3.data_sram_wdata = wdata;

    assign if_l4.data_sram_req   = req_l4;
    assign if_l4.data_sram_wr    = wr;
    assign if_l4.data_sram_size  = size;
    assign if_l4.data_sram_addr  = addr;
    assign if_l4.data_sram_wstrb = wstrb;
    assign if_l4.data_sram_wdata = wdata;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .OUTSTANDING(1)) u_l1 (
        .clk(clk), .resetn(resetn), .addr_stall(addr_stall), .bus(if_l1.slave));
    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .OUTSTANDING(2)) u_l3 (
        .clk(clk), .resetn(resetn), .addr_stall(addr_stall), .bus(if_l3.slave));
    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(4), .OUTSTANDING(2)) u_l4 (
        .clk(clk), .resetn(resetn), .addr_stall(addr_stall), .bus(if_l4.slave));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 16'd0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (if_l1.data_sram_data_ok) begin
            if (exp_q_l1.size() == 0) begin
                check("l1_spurious_dok", {31'd0, if_l1.data_sram_data_ok}, 32'd0);
            end else begin
                e1 = exp_q_l1.pop_front();
                check("l1_rdata", if_l1.data_sram_rdata, e1[31:0]);
                check("l1_due", {16'd0, cyc}, {16'd0, e1[47:32]});
            end
        end else begin
            check("l1_rdata_idle", if_l1.data_sram_rdata, 32'd0);
            if (exp_q_l1.size() != 0 && exp_q_l1[0][47:32] == cyc)
                check("l1_missing_dok", {31'd0, if_l1.data_sram_data_ok}, 32'd1);
        end

        if (if_l3.data_sram_data_ok) begin
            if (exp_q_l3.size() == 0) begin
                check("l3_spurious_dok", {31'd0, if_l3.data_sram_data_ok}, 32'd0);
            end else begin
                e3 = exp_q_l3.pop_front();
                check("l3_rdata", if_l3.data_sram_rdata, e3[31:0]);
                check("l3_due", {16'd0, cyc}, {16'd0, e3[47:32]});
            end
        end else begin
            check("l3_rdata_idle", if_l3.data_sram_rdata, 32'd0);
            if (exp_q_l3.size() != 0 && exp_q_l3[0][47:32] == cyc)
                check("l3_missing_dok", {31'd0, if_l3.data_sram_data_ok}, 32'd1);
        end

        if (if_l4.data_sram_data_ok) begin
            if (exp_q_l4.size() == 0) begin
                check("l4_spurious_dok", {31'd0, if_l4.data_sram_data_ok}, 32'd0);
            end else begin
                e4 = exp_q_l4.pop_front();
                check("l4_rdata", if_l4.data_sram_rdata, e4[31:0]);
                check("l4_due", {16'd0, cyc}, {16'd0, e4[47:32]});
            end
        end else begin
            check("l4_rdata_idle", if_l4.data_sram_rdata, 32'd0);
            if (exp_q_l4.size() != 0 && exp_q_l4[0][47:32] == cyc)
                check("l4_missing_dok", {31'd0, if_l4.data_sram_data_ok}, 32'd1);
        end
    end

    // Driver tasks
    function automatic logic aok_of(input int d);
        case (d)
            0:       return if_l1.data_sram_addr_ok;
            1:       return if_l3.data_sram_addr_ok;
            default: return if_l4.data_sram_addr_ok;
        endcase
    endfunction

    task automatic idle(input int n);
        req_l1     = 1'b0;
        req_l3     = 1'b0;
        req_l4     = 1'b0;
        addr_stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one request on DUT d (0=l1, 1=l3, 2=l4) and keeps req high.
    // The request is expected to be refused for wait_n cycles (with
    // addr_stall held at stall during those cycles), then accepted.
    // Called right after a rising edge.
    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd,
                         input int wait_n, input logic stall,
                         input logic [31:0] exp_rd);
        req_l1 = (d == 0);
        req_l3 = (d == 1);
        req_l4 = (d == 2);
        wr     = w;
        size   = 2'd2;
        addr   = a;
        wstrb  = s;
        wdata  = wd;
        for (int i = 0; i < wait_n; i++) begin
            addr_stall = stall;
            @(negedge clk);
            check("aok_refused", {31'd0, aok_of(d)}, 32'd0);
            @(posedge clk);
            #1;
        end
        addr_stall = 1'b0;
        @(negedge clk);
        check("aok_taken", {31'd0, aok_of(d)}, 32'd1);
        case (d)
            0:       exp_q_l1.push_back({cyc + 16'd1, exp_rd});
            1:       exp_q_l3.push_back({cyc + 16'd3, exp_rd});
            default: exp_q_l4.push_back({cyc + 16'd4, exp_rd});
        endcase
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        resetn     = 1'b0;
        addr_stall = 1'b0;
        req_l1     = 1'b0;
        req_l3     = 1'b0;
        req_l4     = 1'b0;
        wr         = 1'b0;
        size       = 2'd2;
        addr       = 32'd0;
        wstrb      = 4'd0;
        wdata      = 32'd0;

        // Outputs during reset
        @(negedge clk);
        check("rst_l1_aok",   {31'd0, if_l1.data_sram_addr_ok}, 32'd0);
        check("rst_l1_dok",   {31'd0, if_l1.data_sram_data_ok}, 32'd0);
        check("rst_l1_rdata", if_l1.data_sram_rdata, 32'd0);
        check("rst_l3_aok",   {31'd0, if_l3.data_sram_addr_ok}, 32'd0);
        check("rst_l4_aok",   {31'd0, if_l4.data_sram_addr_ok}, 32'd0);
        check("rst_l4_dok",   {31'd0, if_l4.data_sram_data_ok}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // 1: store then load, LATENCY=1, back to back through a 1-deep queue
        issue(0, 1'b1, 32'h10, 4'hF, 32'h11223344, 0, 1'b0, 32'h0);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0,        0, 1'b0, 32'h11223344);
        idle(3);

        // 2: byte-strobe merge and an empty-strobe store
        issue(0, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, 0, 1'b0, 32'h0);
        issue(0, 1'b1, 32'h20, 4'h2, 32'h00005500, 0, 1'b0, 32'h0);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0,        0, 1'b0, 32'hAABB55DD);
        issue(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, 1'b0, 32'h0);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0,        0, 1'b0, 32'hAABB55DD);
        idle(3);

        // 3: load/store ordering on one address, LATENCY=3
        issue(1, 1'b1, 32'h30, 4'hF, 32'h1, 0, 1'b0, 32'h0);
        idle(5);
        issue(1, 1'b0, 32'h30, 4'h0, 32'h0, 0, 1'b0, 32'h1);
        issue(1, 1'b1, 32'h30, 4'hF, 32'h2, 0, 1'b0, 32'h0);
        issue(1, 1'b0, 32'h30, 4'h0, 32'h0, 1, 1'b0, 32'h2);
        idle(5);

        // 4: full queue, LATENCY=4, OUTSTANDING=2
        issue(2, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 0, 1'b0, 32'h0);
        issue(2, 1'b1, 32'h44, 4'hF, 32'h12345678, 0, 1'b0, 32'h0);
        idle(6);
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0,        0, 1'b0, 32'hCAFEF00D);
        issue(2, 1'b0, 32'h44, 4'h0, 32'h0,        0, 1'b0, 32'h12345678);
        issue(2, 1'b1, 32'h40, 4'hC, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0,        0, 1'b0, 32'hDEADF00D);
        idle(6);

        // 5: addr_stall for 3 cycles while a response is due
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0,        0, 1'b0, 32'hDEADF00D);
        idle(1);
        issue(2, 1'b1, 32'h48, 4'hF, 32'h55AA55AA, 3, 1'b1, 32'h0);
        issue(2, 1'b0, 32'h48, 4'h0, 32'h0,        0, 1'b0, 32'h55AA55AA);
        idle(6);

        // 6: reset with two loads outstanding and one response on the bus
        issue(2, 1'b1, 32'h4C, 4'hF, 32'h13579BDF, 0, 1'b0, 32'h0);
        idle(6);
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0, 0, 1'b0, 32'hDEADF00D);
        issue(2, 1'b0, 32'h44, 4'h0, 32'h0, 0, 1'b0, 32'h12345678);
        idle(2);
        check("pre_rst_dok",   {31'd0, if_l4.data_sram_data_ok}, 32'd1);
        check("pre_rst_rdata", if_l4.data_sram_rdata, 32'hDEADF00D);
        resetn = 1'b0;
        exp_q_l4.delete();
        #1;
        check("mid_rst_aok",   {31'd0, if_l4.data_sram_addr_ok}, 32'd0);
        check("mid_rst_dok",   {31'd0, if_l4.data_sram_data_ok}, 32'd0);
        check("mid_rst_rdata", if_l4.data_sram_rdata, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(6);
        issue(2, 1'b0, 32'h4C, 4'h0, 32'h0, 0, 1'b0, 32'h13579BDF);
        idle(6);

        // Every expected response has been seen
        check("l1_drained", exp_q_l1.size(), 32'd0);
        check("l3_drained", exp_q_l3.size(), 32'd0);
        check("l4_drained", exp_q_l4.size(), 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder end of the CPU's SRAM-like data-memory interface. It accepts load/store requests from the pipeline's EX stage and returns load data to the MEM stage. It models a word-organised data RAM with byte-strobe writes, a configurable fixed response latency, and a bounded in-order outstanding-request queue. It serves as the data-memory model for pipeline simulation, and its backpressure input lets benches stress the pipeline's stall paths.

Parameters:
ADDR_WIDTH, 10, log2 of memory depth in 32-bit words; the word index is data_sram_addr[ADDR_WIDTH+1:2] and upper address bits are ignored.
LATENCY, 1, cycles from request acceptance to data_ok; legal range 1..8.
OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..8.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1 = store, 0 = load
data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb is authoritative
data_sram_addr  in  32  byte address
data_sram_wstrb  in  4  byte write enables (store only)
data_sram_wdata  in  32  store data, byte lanes aligned to wstrb
addr_stall  in  1  bench backpressure; when 1, forces addr_ok to 0
data_sram_addr_ok  out  1  request accepted this cycle when high together with req
data_sram_data_ok  out  1  one-cycle response pulse, in order
data_sram_rdata  out  32  load word; valid only while data_ok is high

Behaviour:
- Reset (resetn=0, asynchronous): queue count, pointers and per-entry countdowns clear to 0. addr_ok=0, data_ok=0, rdata=0. Memory contents are not reset; simulation initialises them to 0.
- Acceptance: accept = req & addr_ok.
  - addr_ok = resetn & ~addr_stall & (count < OUTSTANDING | data_ok), evaluated combinationally.
  - Push and pop in the same cycle are permitted when the queue is full.
- Store accepted at edge T:
  - Byte lanes i where wstrb[i]=1 are written at edge T.
  - Lanes with wstrb=0 are unchanged.
  - wstrb=0000 writes nothing but still produces a response.
- Load accepted at edge T:
  - The memory word is read at edge T and captured into the queue entry.
  - The load therefore sees every store accepted strictly before it, and no later store.
  - Returned data is the full aligned word; byte/half extraction and sign extension belong to the MEM stage.
- Queue entry: {wr, captured rdata}, plus a countdown loaded with LATENCY-1 at push.
  - Countdowns of all valid entries decrement each cycle, saturating at 0.
- Response:
  - data_ok = queue non-empty & head countdown == 0.
  - A request accepted at edge T produces data_ok high during the cycle after T+LATENCY-1, i.e. LATENCY cycles after the accepting cycle.
  - The head pops at the edge ending that data_ok cycle.
  - rdata = captured word when the head is a load; 0 when the head is a store or data_ok=0.
- Ordering: responses are strictly in acceptance order. With at most one accept per cycle and a fixed latency, responses never collide.
- Back-to-back: with LATENCY=1 and OUTSTANDING>=1, one request per cycle is sustained; addr_ok stays high through the push/pop overlap.
- Full: count == OUTSTANDING and no data_ok → addr_ok=0; req may stay asserted, and the request is taken once addr_ok returns.
- addr_stall does not delay responses already queued.
- Reset mid-operation: all outstanding requests are dropped and no data_ok is issued for them. Stores already committed remain in memory.
- Out-of-range parameters are a configuration error; the block need not detect them.

Test Plan:
1. LATENCY=1: store addr 0x10, wdata 0x11223344, wstrb 1111; next cycle load 0x10 → store data_ok with rdata 0; load data_ok one cycle later with rdata 0x11223344.
2. Byte-strobe merge: word 0x20 = 0xAABBCCDD; store wdata 0x00005500, wstrb 0010; load 0x20 → rdata 0xAABB55DD.
3. Load then store to the same address in consecutive accepts (LATENCY=3): word 0x30 = 0x1; load 0x30, then store 0x2 → load returns 0x00000001; a following load returns 0x00000002.
4. Full queue (OUTSTANDING=2, LATENCY=4): req held high for 4 cycles → addr_ok low in the third request's cycle until the first data_ok cycle, when the third is accepted; data_ok order matches acceptance order.
5. addr_stall=1 for 3 cycles with req high → no accepts, no memory change; outstanding responses still emerge on schedule; the request is accepted in the cycle addr_stall falls.
6. Assert resetn=0 with 2 loads outstanding → data_ok, addr_ok and rdata are 0 immediately; no data_ok after release; a store committed before reset is read back correctly.
